// File: rtl/ic_pkg.sv
// Shared interconnect definitions: response route codes and the request route encoder.
package ic_pkg;

  typedef logic [1:0] ic_route_t;

  localparam ic_route_t ROUTE_ROM = 2'd0;
  localparam ic_route_t ROUTE_RAM = 2'd1;
  localparam ic_route_t ROUTE_AXI = 2'd2;
  localparam ic_route_t ROUTE_ERR = 2'd3;

  // A decode failure, or a request with no route bit at all, is answered locally
  function automatic ic_route_t encodeRoute(input logic rom, input logic ram,
                                            input logic axi, input logic decErr);
    ic_route_t route;
    if (decErr || !(rom || ram || axi)) route = ROUTE_ERR;
    else if (rom)                       route = ROUTE_ROM;
    else if (ram)                       route = ROUTE_RAM;
    else                                route = ROUTE_AXI;
    return route;
  endfunction

endpackage

// File: rtl/ic_route_fifo.sv
// In-order route tracking FIFO; a push is only visible at the head on the following cycle.
module ic_route_fifo
  import ic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     i_push,
  input  ic_route_t                i_data,
  input  logic                     i_pop,
  output ic_route_t                o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_pushDone,
  output logic                     o_popDone
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ic_route_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_doPush;
  logic              w_doPop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head     = r_mem[r_rptr];
  assign w_doPop    = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_doPush   = i_push && (!o_full || w_doPop);
  assign o_pushDone = w_doPush;
  assign o_popDone  = w_doPop;

  always_ff @(posedge g_clk) begin
    if (w_doPush) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wptr <= r_wptr + 1'b1;
      if (w_doPop)  r_rptr <= r_rptr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ic_rsp_router.sv
// Interconnect response router: returns ROM/RAM/AXI responses in request order.
// Optional stray-response detection is enabled with `define IC_RSP_ROUTER_STRAY_CHECK_EN.
module ic_rsp_router
  import ic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                    g_clk,
  input  logic                    g_resetn,
  input  logic                    req_track,
  input  logic                    req_route_rom,
  input  logic                    req_route_ram,
  input  logic                    req_route_axi,
  input  logic                    req_dec_err,
  output logic                    req_space,
  output logic [$clog2(DEPTH):0]  outstanding,
  input  logic                    rom_rsp_valid,
  output logic                    rom_rsp_ready,
  input  logic                    rom_rsp_error,
  input  logic [DW-1:0]           rom_rsp_rdata,
  input  logic                    ram_rsp_valid,
  output logic                    ram_rsp_ready,
  input  logic                    ram_rsp_error,
  input  logic [DW-1:0]           ram_rsp_rdata,
  input  logic                    axi_rsp_valid,
  output logic                    axi_rsp_ready,
  input  logic                    axi_rsp_error,
  input  logic [DW-1:0]           axi_rsp_rdata,
`ifdef IC_RSP_ROUTER_STRAY_CHECK_EN
  output logic                    err_stray,
`endif
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_error,
  output logic [DW-1:0]           rsp_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  ic_route_t      w_pushRoute;
  ic_route_t      w_head;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic           w_pop;
  logic           w_pushDone;
  logic           w_popDone;

  assign w_pushRoute = encodeRoute(req_route_rom, req_route_ram, req_route_axi, req_dec_err);
  assign w_pop       = rsp_valid && rsp_ready;
  assign req_space   = !w_full;
  assign outstanding = w_count;

  ic_route_fifo #(.DEPTH(DEPTH)) u_fifo (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .i_push     (req_track),
    .i_data     (w_pushRoute),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_pushDone (w_pushDone),
    .o_popDone  (w_popDone)
  );

  // Head mux and ready demux; only the target owning the head ever sees ready
  always_comb begin
    rsp_valid     = 1'b0;
    rsp_error     = 1'b0;
    rsp_rdata     = '0;
    rom_rsp_ready = 1'b0;
    ram_rsp_ready = 1'b0;
    axi_rsp_ready = 1'b0;
    if (!w_empty) begin
      case (w_head)
        ROUTE_ROM: begin
          rsp_valid     = rom_rsp_valid;
          rsp_error     = rom_rsp_error;
          rsp_rdata     = rom_rsp_rdata;
          rom_rsp_ready = rsp_ready;
        end
        ROUTE_RAM: begin
          rsp_valid     = ram_rsp_valid;
          rsp_error     = ram_rsp_error;
          rsp_rdata     = ram_rsp_rdata;
          ram_rsp_ready = rsp_ready;
        end
        ROUTE_AXI: begin
          rsp_valid     = axi_rsp_valid;
          rsp_error     = axi_rsp_error;
          rsp_rdata     = axi_rsp_rdata;
          axi_rsp_ready = rsp_ready;
        end
        default: begin
          rsp_valid = 1'b1;
          rsp_error = 1'b1;
        end
      endcase
    end
  end

`ifdef IC_RSP_ROUTER_STRAY_CHECK_EN
  logic [CW-1:0] r_romCnt;
  logic [CW-1:0] r_ramCnt;
  logic [CW-1:0] r_axiCnt;
  logic          r_errStray;

  function automatic logic [CW-1:0] nextCnt(input logic [CW-1:0] cnt,
                                            input logic inc, input logic dec);
    logic [CW-1:0] res;
    res = cnt;
    if (inc && !dec)      res = cnt + 1'b1;
    else if (dec && !inc) res = cnt - 1'b1;
    return res;
  endfunction

  // Per-target counts of tracked requests; a response from a target with none is stray
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_romCnt   <= '0;
      r_ramCnt   <= '0;
      r_axiCnt   <= '0;
      r_errStray <= 1'b0;
    end else begin
      r_romCnt <= nextCnt(r_romCnt, w_pushDone && (w_pushRoute == ROUTE_ROM),
                          w_popDone && (w_head == ROUTE_ROM));
      r_ramCnt <= nextCnt(r_ramCnt, w_pushDone && (w_pushRoute == ROUTE_RAM),
                          w_popDone && (w_head == ROUTE_RAM));
      r_axiCnt <= nextCnt(r_axiCnt, w_pushDone && (w_pushRoute == ROUTE_AXI),
                          w_popDone && (w_head == ROUTE_AXI));
      if ((rom_rsp_valid && (r_romCnt == '0)) ||
          (ram_rsp_valid && (r_ramCnt == '0)) ||
          (axi_rsp_valid && (r_axiCnt == '0)))
        r_errStray <= 1'b1;
    end
  end

  assign err_stray = r_errStray;
`endif

endmodule
